// File: rtl/tdm_demux8_pkg.sv
// Shared types and defaults for the TDM receive demultiplexer.
package tdm_pkg;

   typedef enum logic {HUNT, LOCKED} tdm_state_t;

   localparam int TDM_NCH_DEFAULT        = 8;
   localparam int TDM_MISS_LIMIT_DEFAULT = 2;

endpackage

// File: rtl/tdm_demux8_slot_counter.sv
// Mod-NCH slot counter: clear beats load1 beats inc; wraps naturally since NCH is a power of 2.
module slot_counter #(
   parameter int NCH = 8,
   parameter int CW  = $clog2(NCH)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          inc,
   input  logic          load1,
   input  logic          clear,
   output logic [CW-1:0] value
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   value <= '0;
      else if (clear) value <= '0;
      else if (load1) value <= CW'(1);
      else if (inc)   value <= value + CW'(1);
   end

endmodule

// File: rtl/tdm_demux8.sv
// TDM receive end: aligns to frame_sync, assembles NCH serial slots into a parallel frame, tracks lock.
module tdm_demux8
   import tdm_pkg::*;
#(
   parameter int NCH        = TDM_NCH_DEFAULT,
   parameter int CW         = $clog2(NCH),
   parameter int MISS_LIMIT = TDM_MISS_LIMIT_DEFAULT
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           en,
   input  logic           din,
   input  logic           frame_sync,
   output logic [NCH-1:0] y,
   output logic           frame_valid,
   output logic           locked,
   output logic           sync_err,
   output logic [CW-1:0]  slot
);

   localparam int MW = $clog2(MISS_LIMIT + 1);

   // One decoded action per enabled bit; the register block just carries it out.
   typedef enum logic [2:0] {
      ACT_NONE, ACT_START, ACT_FLY, ACT_DROP, ACT_SHIFT, ACT_DELIVER, ACT_REALIGN
   } act_t;

   tdm_state_t     state;
   logic [NCH-2:0] shadow;
   logic [MW-1:0]  miss;
   logic [MW-1:0]  miss_inc;
   act_t           act;

   assign miss_inc = miss + MW'(1);

   always_comb begin
      act = ACT_NONE;
      if (en) begin
         if (state == HUNT) begin
            if (frame_sync) act = ACT_START;
         end else if (slot == '0) begin
            if (frame_sync)                     act = ACT_START;
            else if (miss_inc == MW'(MISS_LIMIT)) act = ACT_DROP;
            else                                act = ACT_FLY;
         end else if (frame_sync) begin
            act = ACT_REALIGN;
         end else if (slot == CW'(NCH - 1)) begin
            act = ACT_DELIVER;
         end else begin
            act = ACT_SHIFT;
         end
      end
   end

   slot_counter #(.NCH(NCH), .CW(CW)) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (act == ACT_SHIFT || act == ACT_DELIVER),
      .load1   (act == ACT_START || act == ACT_FLY || act == ACT_REALIGN),
      .clear   (act == ACT_DROP),
      .value   (slot)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= HUNT;
         locked      <= 1'b0;
         shadow      <= '0;
         miss        <= '0;
         y           <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         frame_valid <= (act == ACT_DELIVER);
         sync_err    <= (act == ACT_REALIGN);
         case (act)
            ACT_START: begin
               state     <= LOCKED;
               locked    <= 1'b1;
               miss      <= '0;
               shadow[0] <= din;
            end
            ACT_FLY: begin
               miss      <= miss_inc;
               shadow[0] <= din;
            end
            ACT_DROP: begin
               state  <= HUNT;
               locked <= 1'b0;
               miss   <= '0;
            end
            ACT_SHIFT:   shadow[slot] <= din;
            ACT_DELIVER: y <= {din, shadow};
            ACT_REALIGN: begin
               // Partial frame is thrown away; this bit becomes slot 0 of a new frame.
               shadow    <= '0;
               shadow[0] <= din;
               miss      <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: lock, en gaps, misalignment, loss of lock, mid-frame reset, back-to-back.
module tb_tdm_demux8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       en = 1'b0;
   logic       din = 1'b0;
   logic       frame_sync = 1'b0;
   logic [7:0] y;
   logic       frame_valid, locked, sync_err;
   logic [2:0] slot;

   int n_vec = 0;
   int n_err = 0;

   tdm_demux8 dut (
      .clk(clk), .reset_n(reset_n), .en(en), .din(din), .frame_sync(frame_sync),
      .y(y), .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err), .slot(slot)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
   task automatic drive(input logic e, input logic d, input logic fs);
      @(negedge clk);
      en = e; din = d; frame_sync = fs;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      #12;
      n_vec++; if (y !== 8'h00)      begin n_err++; $display("FAIL reset_y got %h want 00", y); end
      n_vec++; if (locked !== 1'b0)  begin n_err++; $display("FAIL reset_locked got %b want 0", locked); end
      n_vec++; if (slot !== 3'd0)    begin n_err++; $display("FAIL reset_slot got %0d want 0", slot); end
      n_vec++; if (frame_valid !== 1'b0 || sync_err !== 1'b0)
         begin n_err++; $display("FAIL reset_pulses got fv=%b se=%b want 0 0", frame_valid, sync_err); end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_lock_deliver;
      logic [7:0] v = 8'h4D;
      drive(1'b1, v[0], 1'b1);
      n_vec++; if (locked !== 1'b1) begin n_err++; $display("FAIL lock_first got %b want 1", locked); end
      n_vec++; if (slot !== 3'd1)   begin n_err++; $display("FAIL lock_slot got %0d want 1", slot); end
      for (int k = 1; k < 8; k++) begin
         drive(1'b1, v[k], 1'b0);
         if (k < 7) begin
            n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL lock_early_fv slot %0d got %b want 0", k, frame_valid); end
         end
      end
      n_vec++; if (y !== 8'h4D)          begin n_err++; $display("FAIL lock_y got %h want 4d", y); end
      n_vec++; if (frame_valid !== 1'b1) begin n_err++; $display("FAIL lock_fv got %b want 1", frame_valid); end
      n_vec++; if (slot !== 3'd0)        begin n_err++; $display("FAIL lock_wrap got %0d want 0", slot); end
      drive(1'b0, 1'b0, 1'b0);
      n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL lock_fv_pulse got %b want 0", frame_valid); end
   endtask

   task automatic test_en_gaps;
      logic [7:0] v = 8'h4D;
      for (int k = 0; k < 4; k++) drive(1'b1, v[k], k == 0);
      for (int g = 0; g < 2; g++) begin
         drive(1'b0, 1'b1, 1'b1);
         n_vec++; if (slot !== 3'd4)        begin n_err++; $display("FAIL gap_slot got %0d want 4", slot); end
         n_vec++; if (frame_valid !== 1'b0) begin n_err++; $display("FAIL gap_fv got %b want 0", frame_valid); end
      end
      for (int k = 4; k < 8; k++) drive(1'b1, v[k], 1'b0);
      n_vec++; if (y !== 8'h4D || frame_valid !== 1'b1)
         begin n_err++; $display("FAIL gap_deliver got y=%h fv=%b want 4d 1", y, frame_valid); end
   endtask

   task automatic test_misalign;
      logic [7:0] v = 8'hA5;
      for (int k = 0; k < 5; k++) drive(1'b1, 1'b1, k == 0);
      n_vec++; if (slot !== 3'd5) begin n_err++; $display("FAIL mis_pre_slot got %0d want 5", slot); end
      drive(1'b1, v[0], 1'b1);
      n_vec++; if (sync_err !== 1'b1) begin n_err++; $display("FAIL mis_err got %b want 1", sync_err); end
      n_vec++; if (slot !== 3'd1)     begin n_err++; $display("FAIL mis_slot got %0d want 1", slot); end
      n_vec++; if (y !== 8'h4D || frame_valid !== 1'b0)
         begin n_err++; $display("FAIL mis_y_held got y=%h fv=%b want 4d 0", y, frame_valid); end
      drive(1'b1, v[1], 1'b0);
      n_vec++; if (sync_err !== 1'b0) begin n_err++; $display("FAIL mis_err_pulse got %b want 0", sync_err); end
      for (int k = 2; k < 8; k++) drive(1'b1, v[k], 1'b0);
      n_vec++; if (y !== 8'hA5 || frame_valid !== 1'b1)
         begin n_err++; $display("FAIL mis_deliver got y=%h fv=%b want a5 1", y, frame_valid); end
   endtask

   task automatic test_loss_of_lock;
      logic [7:0] v = 8'h3C;
      logic [7:0] w = 8'h96;
      for (int k = 0; k < 8; k++) drive(1'b1, v[k], 1'b0);
      n_vec++; if (y !== 8'h3C || frame_valid !== 1'b1 || locked !== 1'b1)
         begin n_err++; $display("FAIL fly_deliver got y=%h fv=%b lk=%b want 3c 1 1", y, frame_valid, locked); end
      drive(1'b1, 1'b1, 1'b0);
      n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL loss_locked got %b want 0", locked); end
      n_vec++; if (slot !== 3'd0)   begin n_err++; $display("FAIL loss_slot got %0d want 0", slot); end
      for (int k = 0; k < 9; k++) begin
         drive(1'b1, k[0], 1'b0);
         n_vec++; if (frame_valid !== 1'b0 || slot !== 3'd0 || locked !== 1'b0)
            begin n_err++; $display("FAIL hunt_idle got fv=%b slot=%0d lk=%b want 0 0 0", frame_valid, slot, locked); end
      end
      for (int k = 0; k < 8; k++) drive(1'b1, w[k], k == 0);
      n_vec++; if (y !== 8'h96 || frame_valid !== 1'b1 || locked !== 1'b1)
         begin n_err++; $display("FAIL relock got y=%h fv=%b lk=%b want 96 1 1", y, frame_valid, locked); end
   endtask

   task automatic test_reset_mid_frame;
      for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, k == 0);
      n_vec++; if (y !== 8'h96 || locked !== 1'b1 || slot !== 3'd3)
         begin n_err++; $display("FAIL mid_pre got y=%h lk=%b slot=%0d want 96 1 3", y, locked, slot); end
      #2 reset_n = 1'b0;
      #1;
      n_vec++; if (y !== 8'h00 || locked !== 1'b0 || slot !== 3'd0)
         begin n_err++; $display("FAIL mid_reset got y=%h lk=%b slot=%0d want 00 0 0", y, locked, slot); end
      reset_n = 1'b1;
   endtask

   task automatic test_back_to_back;
      logic [7:0] frames [4] = '{8'h01, 8'h80, 8'hFF, 8'h00};
      logic [7:0] v;
      for (int f = 0; f < 4; f++) begin
         v = frames[f];
         for (int k = 0; k < 8; k++) begin
            drive(1'b1, v[k], k == 0);
            n_vec++; if (frame_valid !== (k == 7) || sync_err !== 1'b0)
               begin n_err++; $display("FAIL b2b_pulse f%0d slot %0d got fv=%b se=%b want %b 0", f, k, frame_valid, sync_err, k == 7); end
         end
         n_vec++; if (y !== v) begin n_err++; $display("FAIL b2b_y f%0d got %h want %h", f, y, v); end
      end
   endtask

   initial begin
      test_reset;
      test_lock_deliver;
      test_en_gaps;
      test_misalign;
      test_loss_of_lock;
      test_reset_mid_frame;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tdm_demux8.md
Name: tdm_demux8

Overview:
- Receive end of the 8-channel time-division link whose transmit end is the 8:1 mux scanned by a 3-bit select.
- Takes one serial bit per enabled clock, aligns to the frame-sync marker, and routes slot k to parallel output bit y[k].
- Presents a registered 8-bit frame plus a one-cycle valid pulse.
- Tracks lock/loss of alignment.

Parameters:
- NCH, 8, channels (slots) per frame; must be a power of 2, at least 2.
- CW, $clog2(NCH), slot counter width (derived; do not override).
- MISS_LIMIT, 2, consecutive frames with frame_sync absent at slot 0 before dropping lock; 1 to 7.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  reset; asynchronous assert, active-low, synchronous deassert at system level
- en  input  1  bit strobe; din and frame_sync are sampled only when en=1
- din  input  1  serial data bit for the current slot
- frame_sync  input  1  high with the slot-0 bit of each frame
- y  output  NCH  last complete frame; y[k] = bit received in slot k
- frame_valid  output  1  one-cycle pulse when y has just been updated
- locked  output  1  high while state = LOCKED
- sync_err  output  1  one-cycle pulse on a misaligned frame_sync
- slot  output  CW  slot index expected for the next enabled bit

Behaviour:
- Reset (reset_n=0, asynchronous) clears all state:
  - y=0, frame_valid=0, locked=0, sync_err=0, slot=0.
  - shadow register=0, miss counter=0, state=HUNT.
  - Reset asserted mid-frame discards the partial frame; y returns to 0 immediately.
- All register updates occur on the rising clk edge. When en=0, all state holds, and frame_valid and sync_err are forced to 0 on the next edge (they are pulses, not levels).
- HUNT:
  - en & frame_sync: shadow[0]<=din, slot<=1, miss<=0, go to LOCKED.
  - en & !frame_sync: bit discarded, slot stays 0.
- LOCKED, en=1, slot==0:
  - frame_sync=1: miss<=0, capture shadow[0]<=din, slot<=1.
  - frame_sync=0: if miss+1==MISS_LIMIT, go to HUNT, miss<=0, bit discarded, slot stays 0.
  - Otherwise miss<=miss+1 (flywheel), capture shadow[0]<=din, slot<=1.
- LOCKED, en=1, 0<slot<NCH-1:
  - frame_sync=0: shadow[slot]<=din, slot<=slot+1.
  - frame_sync=1: realign. sync_err pulses next cycle, shadow<=0 except shadow[0]<=din, slot<=1, miss<=0, stay LOCKED; the partial frame is discarded and y is untouched.
- LOCKED, en=1, slot==NCH-1:
  - frame_sync=0: y<={din, shadow[NCH-2:0]}, frame_valid<=1, slot wraps to 0.
  - frame_sync=1: treated as a misaligned sync (realign rule above); no frame is delivered.
- Latency: the edge that samples the slot NCH-1 bit updates y; frame_valid is high during the following cycle. Back-to-back frames with en=1 give a frame_valid pulse every NCH cycles.
- locked is a registered decode of state. slot is the counter value itself.
- The miss counter is sized to hold MISS_LIMIT. Slot counter arithmetic is modulo NCH.

Decomposition:
- Package tdm_pkg:
  - typedef enum logic {HUNT, LOCKED} tdm_state_t.
  - localparam TDM_NCH_DEFAULT = 8.
  - localparam TDM_MISS_LIMIT_DEFAULT = 2.
- Sub-module slot_counter:
  - Parameterised mod-NCH counter with inputs inc and load1 (sets value 1) and clear, plus an async active-low reset.
  - Instantiated once for slot.
- All else (FSM, shadow, miss counter, output regs) stays in tdm_demux8.

Test Plan:
- Reset mid-frame: after 3 LOCKED bits, pulse reset_n low for 1 ns between edges -> y=0, locked=0, slot=0 immediately, without waiting for a clock edge.
- Lock and deliver: frame_sync with slot 0, din stream 1,0,1,1,0,0,1,0 (slots 0..7), en=1 -> locked=1 after the first edge; y=8'b0100_1101 on the 8th edge; frame_valid high for exactly one cycle.
- en gaps: same frame with en=0 inserted for 2 cycles after slot 3 -> identical y=8'h4D; frame_valid is delayed by 2 cycles; slot holds at 4 during the gap.
- Misalignment: frame_sync asserted at slot 5 -> sync_err pulses one cycle; slot=1 next; prior y unchanged; the next full frame 8'hA5 is delivered correctly.
- Loss of lock (MISS_LIMIT=2):
  - One frame without frame_sync is still delivered (flywheel).
  - At the second missing slot-0 sync -> locked=0, and no frame_valid until the next frame_sync.
- Back-to-back: 4 consecutive frames 8'h01, 8'h80, 8'hFF, 8'h00 with en=1 -> frame_valid every 8 cycles; y matches each frame; sync_err=0 throughout.
